// File: rtl/pixel_detect.sv
// VGA pixel classifier: generates active-pixel coordinates, applies colour thresholds
// and a horizontal run-length filter, and reports matched pixels per frame.
module pixel_detect #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RUN_LEN  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic [7:0]  r_min,
    input  logic [7:0]  g_max,
    input  logic [7:0]  b_max,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic [18:0] frame_match_count,
    output logic        frame_done
);

    localparam logic [9:0] X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    state_t      state, state_next;
    logic        vs_prev, blank_prev;
    logic        vs_fall, line_end;
    logic [9:0]  x_cnt, y_cnt;
    logic        x_over;
    logic [7:0]  r_lat, g_lat, b_lat;
    logic [9:0]  s1_x, s1_y;
    logic        s1_blank_n, s1_match;
    logic [3:0]  run_cnt, run_next;
    logic [18:0] acc, acc_inc;

    assign vs_fall  = vs_prev & ~VGA_VS;
    assign line_end = blank_prev & ~VGA_BLANK_N;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_FRAME;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: if (vs_fall) state_next = ACTIVE;
            ACTIVE:     state_next = ACTIVE;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    always_comb begin
        run_next = '0;
        if (s1_blank_n && s1_match)
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 4'd1;
    end

    // Count includes a strobe landing on the same cycle as the frame boundary.
    assign acc_inc = (pixel_valid && acc != '1) ? acc + 19'd1 : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev           <= 1'b0;
            blank_prev        <= 1'b0;
            x_cnt             <= '0;
            y_cnt             <= '0;
            x_over            <= 1'b0;
            r_lat             <= '1;
            g_lat             <= '0;
            b_lat             <= '0;
            s1_x              <= '0;
            s1_y              <= '0;
            s1_blank_n        <= 1'b0;
            s1_match          <= 1'b0;
            run_cnt           <= '0;
            acc               <= '0;
            pixel_x           <= '0;
            pixel_y           <= '0;
            pixel_valid       <= 1'b0;
            frame_match_count <= '0;
            frame_done        <= 1'b0;
        end else begin
            vs_prev    <= VGA_VS;
            blank_prev <= VGA_BLANK_N;

            // Pixels past the last column keep the saturated tag but can never match.
            s1_x       <= x_cnt;
            s1_y       <= y_cnt;
            s1_blank_n <= VGA_BLANK_N;
            s1_match   <= (VGA_R >= r_lat) && (VGA_G <= g_lat) && (VGA_B <= b_lat) && !x_over;

            pixel_valid <= (run_next == RUN_MAX) && (state == ACTIVE);
            if ((run_next == RUN_MAX) && (state == ACTIVE)) begin
                pixel_x <= s1_x;
                pixel_y <= s1_y;
            end

            frame_done <= 1'b0;
            if (vs_fall) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                x_over  <= 1'b0;
                run_cnt <= '0;
                acc     <= '0;
                r_lat   <= r_min;
                g_lat   <= g_max;
                b_lat   <= b_max;
                if (state == ACTIVE) begin
                    frame_match_count <= acc_inc;
                    frame_done        <= 1'b1;
                end
            end else begin
                run_cnt <= line_end ? '0 : run_next;
                acc     <= acc_inc;
                if (state == ACTIVE) begin
                    if (line_end) begin
                        x_cnt  <= '0;
                        x_over <= 1'b0;
                        if (y_cnt != Y_LAST) y_cnt <= y_cnt + 10'd1;
                    end else if (VGA_BLANK_N) begin
                        if (x_cnt == X_LAST) x_over <= 1'b1;
                        else                 x_cnt  <= x_cnt + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_detect.sv
// Randomized and directed bench for pixel_detect: a line/frame-level reference model
// feeds expected strobes and frame counts into queues that a monitor checks.
module tb_pixel_detect;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        VGA_VS = 1'b0;
    logic        VGA_BLANK_N = 1'b0;
    logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic [7:0]  r_min = 8'd200, g_max = 8'd50, b_max = 8'd50;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_valid;
    logic [18:0] frame_match_count;
    logic        frame_done;

    pixel_detect #(.H_ACTIVE(640), .V_ACTIVE(480), .RUN_LEN(3)) dut (
        .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .r_min(r_min), .g_max(g_max), .b_max(b_max),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .frame_match_count(frame_match_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int x; int y; int t; } exp_t;
    exp_t pq[$];
    int   fq[$];
    logic [23:0] line_q[$];

    int total = 0, bad = 0;
    int last_x = 0, last_y = 0;

    // Reference model state: thresholds seen at the last frame start, position, run length.
    int m_r = 255, m_g = 0, m_b = 0;
    bit m_act = 0, m_inline = 0;
    int m_line = 0, m_idx = 0, m_run = 0, m_cnt = 0;

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLACK = 24'h000000;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic pix(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]); g = int'(c[15:8]); b = int'(c[7:0]);
        @(negedge clk);
        VGA_BLANK_N = 1'b1;
        VGA_R = c[23:16]; VGA_G = c[15:8]; VGA_B = c[7:0];
        if (m_idx < 640 && r >= m_r && g <= m_g && b <= m_b) m_run++;
        else m_run = 0;
        if (m_act && m_run >= 3) begin
            pq.push_back('{x: m_idx, y: (m_line > 479 ? 479 : m_line), t: cyc + 2});
            m_cnt++;
        end
        m_idx++;
        m_inline = 1;
    endtask

    task automatic blank(input int n);
        repeat (n) begin
            @(negedge clk);
            VGA_BLANK_N = 1'b0;
            VGA_R = '0; VGA_G = '0; VGA_B = '0;
            if (m_inline) begin
                m_line++; m_idx = 0; m_run = 0; m_inline = 0;
            end
        end
    endtask

    task automatic fill(input int n, input logic [23:0] c);
        for (int i = 0; i < n; i++) line_q.push_back(c);
    endtask

    task automatic send_line();
        while (line_q.size() > 0) pix(line_q.pop_front());
        blank(4);
    endtask

    task automatic vsync();
        VGA_VS = 1'b1;
        blank(3);
        @(negedge clk);
        VGA_BLANK_N = 1'b0;
        VGA_VS = 1'b0;
        if (m_act) fq.push_back(m_cnt);
        m_cnt = 0; m_act = 1;
        m_r = int'(r_min); m_g = int'(g_max); m_b = int'(b_max);
        m_line = 0; m_idx = 0; m_run = 0; m_inline = 0;
        blank(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        pq.delete(); fq.delete();
        m_act = 0; m_r = 255; m_g = 0; m_b = 0; m_run = 0; m_cnt = 0;
        last_x = 0; last_y = 0;
        #1;
        chk("rst_pixel_valid", int'(pixel_valid), 0);
        chk("rst_pixel_x", int'(pixel_x), 0);
        chk("rst_pixel_y", int'(pixel_y), 0);
        chk("rst_frame_count", int'(frame_match_count), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (pixel_valid) begin
                total++;
                if (pq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe: got x=%0d y=%0d at cycle %0d, none expected",
                             pixel_x, pixel_y, cyc);
                end else begin
                    exp_t e;
                    e = pq.pop_front();
                    if (int'(pixel_x) != e.x || int'(pixel_y) != e.y || cyc != e.t) begin
                        bad++;
                        $display("FAIL strobe: got x=%0d y=%0d cycle=%0d expected x=%0d y=%0d cycle=%0d",
                                 pixel_x, pixel_y, cyc, e.x, e.y, e.t);
                    end
                    last_x = e.x; last_y = e.y;
                end
            end else begin
                total++;
                if (int'(pixel_x) != last_x || int'(pixel_y) != last_y) begin
                    bad++;
                    $display("FAIL coord_hold: got x=%0d y=%0d expected x=%0d y=%0d",
                             pixel_x, pixel_y, last_x, last_y);
                end
            end
            if (frame_done) begin
                total++;
                if (fq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame_done: got count=%0d, no pulse expected",
                             frame_match_count);
                end else begin
                    int ef;
                    ef = fq.pop_front();
                    if (int'(frame_match_count) != ef) begin
                        bad++;
                        $display("FAIL frame_count: got %0d expected %0d", frame_match_count, ef);
                    end
                end
            end
        end
    end

    initial begin
        #1;
        chk("init_pixel_valid", int'(pixel_valid), 0);
        chk("init_frame_count", int'(frame_match_count), 0);
        chk("init_frame_done", int'(frame_done), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // All-black frame: no strobes, frame count 0.
        vsync();
        repeat (4) begin fill(40, BLACK); send_line(); end
        vsync();

        // Red run on line 10, split runs on line 11, line-wrap run on lines 12/13.
        for (int l = 0; l < 10; l++) begin fill(8, BLACK); send_line(); end
        fill(120, BLACK);
        for (int i = 100; i <= 104; i++) line_q[i] = RED;
        send_line();
        fill(110, BLACK);
        line_q[100] = RED; line_q[101] = RED;
        for (int i = 103; i <= 105; i++) line_q[i] = RED;
        send_line();
        fill(640, BLACK);
        line_q[638] = RED; line_q[639] = RED;
        send_line();
        fill(1, RED); fill(5, BLACK); send_line();
        vsync();

        // Threshold change mid-frame only takes effect at the next frame start.
        repeat (2) begin fill(6, 24'hDC0000); send_line(); end
        r_min = 8'd250;
        repeat (2) begin fill(6, 24'hDC0000); send_line(); end
        vsync();
        fill(6, 24'hDC0000); send_line();
        r_min = 8'd200;
        vsync();

        // Reset in the middle of a red run on line 200.
        for (int l = 0; l < 200; l++) begin fill(2, BLACK); send_line(); end
        for (int i = 0; i < 10; i++) pix(RED);
        do_reset();
        for (int i = 0; i < 5; i++) pix(RED);
        blank(4);
        vsync();
        fill(5, RED); send_line();
        vsync();

        // Overlong line saturates x; next line restarts at 0.
        fill(700, RED); send_line();
        fill(5, RED); send_line();
        vsync();

        // y saturation.
        for (int l = 0; l < 482; l++) begin fill(3, RED); send_line(); end
        vsync();

        // Randomized frames with random thresholds.
        for (int f = 0; f < 6; f++) begin
            r_min = 8'($urandom_range(230, 150));
            g_max = 8'($urandom_range(70, 20));
            b_max = 8'($urandom_range(70, 20));
            vsync();
            for (int l = 0; l < 8; l++) begin
                int n;
                n = (l == 7 && f == 2) ? 650 : int'($urandom_range(80, 1));
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(3, 0) != 0)
                        line_q.push_back({8'($urandom_range(255, 150)),
                                          8'($urandom_range(80, 0)), 8'($urandom_range(80, 0))});
                    else
                        line_q.push_back(24'($urandom));
                end
                send_line();
            end
        end
        vsync();

        repeat (6) @(negedge clk);
        chk("pending_strobes", pq.size(), 0);
        chk("pending_frames", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_detect.md
Name: pixel_detect

Overview:
- Upstream stage of the corner-tracking FSM. Consumes the raw VGA pixel stream (RGB, blanking, vsync) and generates the x/y coordinates of each active pixel.
- Classifies each pixel against colour thresholds and rejects isolated noise with a horizontal run-length filter.
- Drives pixel_x, pixel_y and pixel_valid for the downstream corner FSM. Also reports a per-frame count of matched pixels.

Parameters:
- H_ACTIVE, 640, active pixels per line; x saturates at H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; y saturates at V_ACTIVE-1.
- RUN_LEN, 3, consecutive matching pixels (same line) required before pixel_valid asserts; legal range 1..15.

Ports:
- clk  in  1  pixel clock; one pixel per cycle while VGA_BLANK_N=1
- reset  in  1  asynchronous, active-low reset
- VGA_VS  in  1  vertical sync; a falling edge marks frame start
- VGA_BLANK_N  in  1  1 = active pixel on this cycle
- VGA_R, VGA_G, VGA_B  in  8 each  pixel colour
- r_min  in  8  match requires R >= r_min
- g_max  in  8  match requires G <= g_max
- b_max  in  8  match requires B <= b_max
- pixel_x  out  10  unsigned column of the qualified pixel
- pixel_y  out  10  unsigned row of the qualified pixel
- pixel_valid  out  1  qualified-pixel strobe, one cycle per pixel
- frame_match_count  out  19  qualified pixels in the previous frame
- frame_done  out  1  one-cycle pulse when frame_match_count updates

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: pixel_x=0, pixel_y=0, pixel_valid=0, frame_match_count=0, frame_done=0.
  - Internal: state=WAIT_FRAME; x/y counters=0; run counter=0; latched thresholds r=255, g=0, b=0 (matches only pure red until the first frame latch); VGA_VS_prev=0.
  - Reset mid-frame discards all partial-frame state.
- Edge detection:
  - VGA_VS_prev and blank_prev are registered every cycle.
  - vs_fall = VGA_VS_prev & ~VGA_VS.
  - line_end = blank_prev & ~VGA_BLANK_N.
- State machine:
  - WAIT_FRAME: pixel_valid held 0; no counting. On vs_fall -> ACTIVE.
  - ACTIVE: normal operation. Stays in ACTIVE; only reset returns to WAIT_FRAME.
- Actions on vs_fall (both states):
  - Latch r_min/g_max/b_max into the internal threshold registers. Thresholds never change mid-frame.
  - Clear x and y counters, run counter, and the frame accumulator.
- Additional actions on vs_fall in ACTIVE only:
  - frame_match_count <= accumulator value, including any increment on the same cycle.
  - frame_done=1 for exactly one cycle.
- Coordinate counters:
  - x increments on each cycle with VGA_BLANK_N=1, saturating at H_ACTIVE-1.
  - On line_end: x <= 0; y increments, saturating at V_ACTIVE-1; run counter <= 0.
  - Pixels arriving after x has saturated are tagged x=H_ACTIVE-1 and never qualify; the run counter is forced to 0 for them.
- Pipeline, with 2-cycle fixed latency from input pixel to output:
  - Stage 1 registers x, y, blank_n, and match = (R>=r_lat)&(G<=g_lat)&(B<=b_lat).
  - Stage 2 updates the run counter (4-bit, saturating at RUN_LEN):
    - stage-1 blank_n=1 and match=1: increment;
    - non-match or blank: reset to 0.
  - pixel_valid=1 when the updated run count equals RUN_LEN and state=ACTIVE.
  - pixel_x/pixel_y carry the stage-1 coordinates, i.e. the last pixel of the run.
  - Net effect: the first RUN_LEN-1 matching pixels of a run never strobe; every later matching pixel of the run does.
  - pixel_x/pixel_y hold their last value when pixel_valid=0.
- Accumulator: 19 bits, increments on each pixel_valid, saturates at 2^19-1.
- Simultaneous events:
  - vs_fall and line_end on the same cycle: the vs_fall clear takes priority (y=0, not incremented).
  - Runs never span lines or frames.

Test Plan:
- Reset, then one frame of 640x480 all-black, then vs_fall -> pixel_valid never asserts; frame_done pulses once with frame_match_count=0.
- Thresholds r_min=200, g_max=50, b_max=50. Line 10 has pixels x=100..104 = (255,0,0), all others black; RUN_LEN=3 -> pixel_valid on x=102,103,104, y=10, each 2 cycles after its input pixel; at the next vs_fall, frame_match_count=3.
- Pixels (255,0,0) at x=100,101, a black pixel at x=102, then red at x=103..105 -> only x=105 strobes; a run of 2 red pixels at x=638..639 followed by red at x=0 of the next line -> no strobe.
- Change r_min from 200 to 250 mid-frame while feeding R=220 -> matching continues under the old threshold until the next vs_fall, then stops.
- Pulse reset low during line 200 with a red run in progress -> all outputs 0 immediately; no pixel_valid until after the next vs_fall; no frame_done on that first vs_fall.
- Feed 700 active pixels on one line, all red -> strobes stop after x=639; x holds at 639; no strobes for the extra 60 pixels; the next line restarts at x=0.
